// File: rtl/qtable_update_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qtable_update_sched_pkg
// Brief    : Shared types and constants for the Q-table update scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package qtable_update_sched_pkg;

    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 11;

    localparam logic [2:0] PKT_FEEDBACK    = 3'd1;
    localparam logic [2:0] PKT_CH_ANNOUNCE = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ROUTE  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ABORT  = 3'd4
    } sched_state_t;

    typedef enum logic {
        OWNER_READER = 1'b0,
        OWNER_ENGINE = 1'b1
    } owner_t;

    function automatic logic pkt_type_supported(input logic [2:0] pkt_type);
        return (pkt_type == PKT_FEEDBACK) || (pkt_type == PKT_CH_ANNOUNCE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qtable_update_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : qtable_update_sched_if
// Brief    : Packet, update-engine, route-reader and memory-port signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface qtable_update_sched_if
    import qtable_update_sched_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [WORD_WIDTH-1:0] pkt_source_id;
    logic [WORD_WIDTH-1:0] pkt_cluster_id;
    logic [WORD_WIDTH-1:0] pkt_energy;
    logic [WORD_WIDTH-1:0] pkt_qvalue;
    logic [2:0]            pkt_type;

    logic                  upd_en;
    logic [WORD_WIDTH-1:0] upd_source_id;
    logic [WORD_WIDTH-1:0] upd_cluster_id;
    logic [WORD_WIDTH-1:0] upd_energy;
    logic [WORD_WIDTH-1:0] upd_qvalue;
    logic                  upd_abort;
    logic                  upd_done;
    logic [ADDR_WIDTH-1:0] upd_mem_addr;
    logic                  upd_mem_wr_en;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [7:0]            drop_count;
    logic                  err_timeout;

    modport master (
        output pkt_valid, pkt_source_id, pkt_cluster_id, pkt_energy, pkt_qvalue, pkt_type,
        output upd_done, upd_mem_addr, upd_mem_wr_en, rd_req, rd_addr,
        input  pkt_ready, upd_en, upd_source_id, upd_cluster_id, upd_energy, upd_qvalue,
        input  upd_abort, rd_gnt, mem_addr, mem_wr_en, drop_count, err_timeout
    );

    modport slave (
        input  pkt_valid, pkt_source_id, pkt_cluster_id, pkt_energy, pkt_qvalue, pkt_type,
        input  upd_done, upd_mem_addr, upd_mem_wr_en, rd_req, rd_addr,
        output pkt_ready, upd_en, upd_source_id, upd_cluster_id, upd_energy, upd_qvalue,
        output upd_abort, rd_gnt, mem_addr, mem_wr_en, drop_count, err_timeout
    );

endinterface
`default_nettype wire

// File: rtl/qtable_update_sched_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qtable_update_sched_pkt_fifo
// Brief    : Circular synchronous FIFO holding packed packet fields.
// Revision : 1.0 - initial release
// ============================================================================
module qtable_update_sched_pkt_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/qtable_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : qtable_update_sched
// Brief    : Buffers update packets, launches the Q-table engine with timeout,
//            and shares the neighbor-table port with the route reader.
// Revision : 1.0 - initial release
// ============================================================================
module qtable_update_sched
    import qtable_update_sched_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  rst,
    qtable_update_sched_if.slave  bus
);
    localparam int PKT_WIDTH = 4 * WORD_WIDTH;
    localparam int TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] C_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    owner_t                r_last_owner;
    logic [TW-1:0]         r_timer;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_cluster;
    logic [WORD_WIDTH-1:0] r_energy;
    logic [WORD_WIDTH-1:0] r_qvalue;
    logic [7:0]            r_drop_count;
    logic                  r_err_timeout;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [PKT_WIDTH-1:0]  w_fifo_head;
    logic                  w_pkt_ready;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_upd_en;
    logic                  w_upd_abort;
    logic                  w_rd_gnt;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_wr_en;

    assign w_pkt_ready = !w_fifo_full && !rst;
    assign w_accept    = bus.pkt_valid && w_pkt_ready;
    assign w_push      = w_accept && pkt_type_supported(bus.pkt_type);
    assign w_drop      = w_accept && !pkt_type_supported(bus.pkt_type);

    qtable_update_sched_pkt_fifo #(
        .DATA_WIDTH (PKT_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_pkt_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (w_push),
        .push_data ({bus.pkt_source_id, bus.pkt_cluster_id, bus.pkt_energy, bus.pkt_qvalue}),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // The head is popped on the edge entering LAUNCH so the fields are
    // already valid while upd_en is high.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_upd_en    = 1'b0;
        w_upd_abort = 1'b0;
        w_rd_gnt    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wr_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rd_req && (w_fifo_empty || r_last_owner == OWNER_ENGINE)) begin
                    w_state_nxt = ST_ROUTE;
                end else if (!w_fifo_empty) begin
                    w_state_nxt = ST_LAUNCH;
                    w_pop       = 1'b1;
                end
            end
            ST_ROUTE: begin
                w_rd_gnt    = 1'b1;
                w_mem_addr  = bus.rd_addr;
                w_state_nxt = ST_IDLE;
            end
            ST_LAUNCH: begin
                w_upd_en    = 1'b1;
                w_mem_addr  = bus.upd_mem_addr;
                w_mem_wr_en = bus.upd_mem_wr_en;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_mem_addr  = bus.upd_mem_addr;
                w_mem_wr_en = bus.upd_mem_wr_en;
                if (bus.upd_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == C_TIMER_LAST) begin
                    w_state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                w_upd_abort = 1'b1;
                w_mem_addr  = bus.upd_mem_addr;
                w_mem_wr_en = bus.upd_mem_wr_en;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_owner  <= OWNER_READER;
            r_timer       <= '0;
            r_src         <= '0;
            r_cluster     <= '0;
            r_energy      <= '0;
            r_qvalue      <= '0;
            r_drop_count  <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) {r_src, r_cluster, r_energy, r_qvalue} <= w_fifo_head;
            case (r_state)
                ST_ROUTE:  r_last_owner <= OWNER_READER;
                ST_LAUNCH: begin
                    r_last_owner <= OWNER_ENGINE;
                    r_timer      <= '0;
                end
                ST_WAIT:   r_timer <= r_timer + 1'b1;
                ST_ABORT:  r_err_timeout <= 1'b1;
                default:   ;
            endcase
            if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign bus.pkt_ready      = w_pkt_ready;
    assign bus.upd_en         = w_upd_en;
    assign bus.upd_abort      = w_upd_abort;
    assign bus.rd_gnt         = w_rd_gnt;
    assign bus.mem_addr       = w_mem_addr;
    assign bus.mem_wr_en      = w_mem_wr_en;
    assign bus.upd_source_id  = r_src;
    assign bus.upd_cluster_id = r_cluster;
    assign bus.upd_energy     = r_energy;
    assign bus.upd_qvalue     = r_qvalue;
    assign bus.drop_count     = r_drop_count;
    assign bus.err_timeout    = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_qtable_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtable_update_sched
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qtable_update_sched;
    import qtable_update_sched_pkg::*;

    localparam int WW = 16;
    localparam int AW = 11;
    localparam int FD = 4;
    localparam int TO = 256;

    localparam int M_IDLE   = 0;
    localparam int M_ROUTE  = 1;
    localparam int M_LAUNCH = 2;
    localparam int M_WAIT   = 3;
    localparam int M_ABORT  = 4;

    typedef struct packed {
        logic [WW-1:0] src;
        logic [WW-1:0] cl;
        logic [WW-1:0] en;
        logic [WW-1:0] q;
    } pkt_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    qtable_update_sched_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    qtable_update_sched #(
        .WORD_WIDTH     (WW),
        .ADDR_WIDTH     (AW),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    pkt_t mq[$];
    int   mst = M_IDLE;
    bit   m_last_eng = 1'b0;
    pkt_t m_held = '0;
    int   m_waited = 0;
    int   m_drops = 0;
    bit   m_err = 1'b0;

    // Observation logs of DUT activity
    int            cyc = 0;
    int            n_launch = 0;
    int            n_served = 0;
    logic [WW-1:0] launch_src[$];
    int            launch_cyc[$];
    int            abort_cyc[$];
    byte           ev[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst        = M_IDLE;
        m_last_eng = 1'b0;
        m_held     = '0;
        m_waited   = 0;
        m_drops    = 0;
        m_err      = 1'b0;
    endtask

    task automatic model_compare();
        logic [AW:0] exp_mem;
        exp_mem = '0;
        if (mst == M_ROUTE) exp_mem = {bus.rd_addr, 1'b0};
        else if (mst == M_LAUNCH || mst == M_WAIT || mst == M_ABORT)
            exp_mem = {bus.upd_mem_addr, bus.upd_mem_wr_en};
        chk("pkt_ready", bus.pkt_ready, mq.size() < FD);
        chk("upd_en", bus.upd_en, mst == M_LAUNCH);
        chk("rd_gnt", bus.rd_gnt, mst == M_ROUTE);
        chk("upd_abort", bus.upd_abort, mst == M_ABORT);
        chk("upd_fields", {bus.upd_source_id, bus.upd_cluster_id, bus.upd_energy, bus.upd_qvalue}, m_held);
        chk("mem_port", {bus.mem_addr, bus.mem_wr_en}, exp_mem);
        chk("drop_count", bus.drop_count, m_drops);
        chk("err_timeout", bus.err_timeout, m_err);
    endtask

    task automatic model_advance();
        bit   accept;
        bit   was_empty;
        pkt_t p;
        accept    = bus.pkt_valid && (mq.size() < FD);
        was_empty = (mq.size() == 0);
        case (mst)
            M_IDLE: begin
                if (bus.rd_req && (was_empty || m_last_eng)) mst = M_ROUTE;
                else if (!was_empty) begin
                    m_held = mq.pop_front();
                    mst    = M_LAUNCH;
                end
            end
            M_ROUTE: begin
                m_last_eng = 1'b0;
                mst        = M_IDLE;
            end
            M_LAUNCH: begin
                m_last_eng = 1'b1;
                m_waited   = 0;
                mst        = M_WAIT;
            end
            M_WAIT: begin
                if (bus.upd_done) mst = M_IDLE;
                else begin
                    m_waited++;
                    if (m_waited == TO) mst = M_ABORT;
                end
            end
            default: begin
                m_err = 1'b1;
                mst   = M_IDLE;
            end
        endcase
        if (accept) begin
            if (bus.pkt_type == PKT_FEEDBACK || bus.pkt_type == PKT_CH_ANNOUNCE) begin
                p = {bus.pkt_source_id, bus.pkt_cluster_id, bus.pkt_energy, bus.pkt_qvalue};
                mq.push_back(p);
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
    endtask

    // Inputs change just after posedge, so the falling edge sees them settled.
    initial begin : compare_proc
        forever begin
            @(negedge clock);
            cyc++;
            if (rst) begin
                model_reset();
                chk("reset_ctrl", {bus.pkt_ready, bus.upd_en, bus.upd_abort, bus.rd_gnt, bus.mem_wr_en,
                                   bus.err_timeout, bus.drop_count, bus.mem_addr}, '0);
                chk("reset_fields", {bus.upd_source_id, bus.upd_cluster_id, bus.upd_energy, bus.upd_qvalue}, '0);
            end else begin
                if (bus.upd_en) begin
                    n_launch++;
                    launch_src.push_back(bus.upd_source_id);
                    launch_cyc.push_back(cyc);
                    ev.push_back("L");
                end
                if (bus.rd_gnt) ev.push_back("G");
                if (bus.upd_abort) abort_cyc.push_back(cyc);
                model_compare();
                model_advance();
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.pkt_valid      = 1'b0;
        bus.pkt_type       = 3'd0;
        bus.pkt_source_id  = '0;
        bus.pkt_cluster_id = '0;
        bus.pkt_energy     = '0;
        bus.pkt_qvalue     = '0;
        bus.upd_done       = 1'b0;
        bus.upd_mem_addr   = AW'(11'h055);
        bus.upd_mem_wr_en  = 1'b1;
        bus.rd_req         = 1'b0;
        bus.rd_addr        = AW'(11'h123);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) tick();
        #1 rst = 1'b0;
        tick();
        n_served = n_launch;
    endtask

    task automatic send(input logic [2:0] t, input logic [WW-1:0] src, input logic [WW-1:0] q);
        int guard;
        guard = 0;
        bus.pkt_valid      = 1'b1;
        bus.pkt_type       = t;
        bus.pkt_source_id  = src;
        bus.pkt_cluster_id = src ^ 16'h0A0A;
        bus.pkt_energy     = src + 16'h0100;
        bus.pkt_qvalue     = q;
        while (!bus.pkt_ready && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) chk("send_ready_timeout", guard, 0);
        tick();
        bus.pkt_valid = 1'b0;
    endtask

    task automatic serve_to(input int target);
        int guard;
        while (n_served < target) begin
            guard = 0;
            while (n_launch <= n_served && guard < 2000) begin
                tick();
                guard++;
            end
            if (guard >= 2000) begin
                chk("serve_launch_timeout", n_launch, n_served + 1);
                return;
            end
            repeat (3) tick();
            bus.upd_done = 1'b1;
            tick();
            bus.upd_done = 1'b0;
            n_served++;
        end
    endtask

    initial begin : stimulus
        int  base;
        int  nab;
        int  guard;
        int  ev0;
        byte exp_ev [5];
        exp_ev = '{"L", "G", "L", "G", "L"};

        drive_idle();
        rst = 1'b1;
        repeat (3) tick();
        #1 rst = 1'b0;
        tick();
        chk("ready_after_reset", bus.pkt_ready, 1);
        chk("drop_after_reset", bus.drop_count, 0);

        // Single FEEDBACK packet: upd_en two cycles after acceptance
        send(PKT_FEEDBACK, 16'h0005, 16'h0040);
        chk("t1_no_en_yet", bus.upd_en, 0);
        tick();
        chk("t1_en_pulse", bus.upd_en, 1);
        chk("t1_src", bus.upd_source_id, 16'h0005);
        chk("t1_qvalue", bus.upd_qvalue, 16'h0040);
        tick();
        chk("t1_en_single", bus.upd_en, 0);
        repeat (9) tick();
        bus.upd_done = 1'b1;
        tick();
        bus.upd_done = 1'b0;
        n_served = n_launch;
        chk("t1_err_clear", bus.err_timeout, 0);

        // Burst of five: FIFO fills, order preserved
        base = n_launch;
        for (int i = 0; i < 5; i++) send(PKT_CH_ANNOUNCE, WW'(16'h0010 + i), WW'(16'h0100 + i));
        chk("t2_full_after_burst", bus.pkt_ready, 0);
        serve_to(base + 5);
        chk("t2_launch_count", n_launch - base, 5);
        for (int k = 0; k < 5; k++) begin
            if (launch_src.size() > base + k)
                chk("t2_order", launch_src[base + k], WW'(16'h0010 + k));
        end

        // Unsupported types are dropped, count saturates
        base = n_launch;
        bus.pkt_valid = 1'b1;
        bus.pkt_type  = 3'd5;
        repeat (300) tick();
        bus.pkt_valid = 1'b0;
        tick();
        chk("t3_drop_sat", bus.drop_count, 255);
        chk("t3_no_launch", n_launch - base, 0);

        // Timeout: abort after TO cycles in WAIT, then next packet launches
        base = n_launch;
        nab  = abort_cyc.size();
        send(PKT_FEEDBACK, 16'h0020, 16'h0001);
        send(PKT_FEEDBACK, 16'h0021, 16'h0002);
        guard = 0;
        while ((abort_cyc.size() <= nab || n_launch < base + 2) && guard < 600) begin
            tick();
            guard++;
        end
        if (guard >= 600) chk("t4_abort_timeout", abort_cyc.size(), nab + 1);
        else begin
            chk("t4_abort_cycle", abort_cyc[nab] - launch_cyc[base], TO + 1);
            chk("t4_relaunch_gap", launch_cyc[base + 1] - abort_cyc[nab], 2);
            chk("t4_relaunch_src", launch_src[base + 1], 16'h0021);
        end
        chk("t4_err_set", bus.err_timeout, 1);
        n_served = base + 1;
        serve_to(base + 2);
        chk("t4_err_sticky", bus.err_timeout, 1);

        // Fairness with reader requesting continuously
        do_reset();
        ev0 = ev.size();
        send(PKT_FEEDBACK, 16'h0030, 16'h0003);
        send(PKT_FEEDBACK, 16'h0031, 16'h0004);
        send(PKT_CH_ANNOUNCE, 16'h0032, 16'h0005);
        bus.rd_req = 1'b1;
        serve_to(n_served + 3);
        tick();
        bus.rd_req = 1'b0;
        chk("t5_event_count", ev.size() >= ev0 + 5, 1);
        for (int k = 0; k < 5; k++) begin
            if (ev.size() > ev0 + k) chk("t5_grant_order", ev[ev0 + k], exp_ev[k]);
        end
        repeat (2) tick();

        // Asynchronous reset while waiting with packets queued
        send(3'd7, 16'h0099, 16'h0000);
        base = n_launch;
        nab  = abort_cyc.size();
        send(PKT_FEEDBACK, 16'h0040, 16'h0006);
        send(PKT_FEEDBACK, 16'h0041, 16'h0007);
        send(PKT_FEEDBACK, 16'h0042, 16'h0008);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_async_ctrl", {bus.pkt_ready, bus.upd_en, bus.upd_abort, bus.rd_gnt, bus.mem_wr_en,
                              bus.err_timeout, bus.drop_count, bus.mem_addr}, '0);
        chk("t6_async_fields", {bus.upd_source_id, bus.upd_qvalue}, '0);
        repeat (2) tick();
        #1 rst = 1'b0;
        tick();
        chk("t6_ready_after", bus.pkt_ready, 1);
        repeat (5) tick();
        chk("t6_fifo_flushed", n_launch - base, 1);
        chk("t6_no_abort", abort_cyc.size() - nab, 0);
        n_served = n_launch;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.pkt_valid      = ($urandom_range(0, 1) == 1);
            bus.pkt_type       = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                             : 3'($urandom_range(1, 2));
            bus.pkt_source_id  = WW'($urandom);
            bus.pkt_cluster_id = WW'($urandom);
            bus.pkt_energy     = WW'($urandom);
            bus.pkt_qvalue     = WW'($urandom);
            bus.upd_done       = ($urandom_range(0, 3) == 0);
            bus.rd_req         = ($urandom_range(0, 9) < 3);
            bus.rd_addr        = AW'($urandom);
            bus.upd_mem_addr   = AW'($urandom);
            bus.upd_mem_wr_en  = ($urandom_range(0, 1) == 1);
            tick();
        end
        drive_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
